beaten_pix_sched: RTL and testbench
===================================

// Module: beaten_pix_sched
// PURPOSE
//  Scheduler for beaten (dead/hot) pixel handling in the thermal ADC pixel stream.
//  - On request, runs one calibration frame: records raster addresses of pixels above BEATEN_PIX_LEVEL into a table.
//  - In every later frame, replaces each listed pixel with the last good pixel of that frame.
//  - Sits between the ADC capture and the frame buffer, on the ADC clock.
// PARAMETERS
//  COLS     384  pixels per line
//  ROWS     288  lines per frame
//  MAX_BAD  64   table depth (entries)
//  ADDR_W   17   raster address width; must satisfy 2^ADDR_W >= COLS*ROWS
// PORTS
//  CLK              in   1           pixel clock; all logic on the rising edge
//  RST              in   1           synchronous reset, active-high
//  CAL_REQ          in   1           one-cycle pulse: calibrate on the next frame
//  BEATEN_PIX_LEVEL in   ADC_WIDHT   threshold; a pixel is bad when PIX_DATA > level (unsigned)
//  FRAME_START      in   1           qualifies pixel 0; asserted together with PIX_VALID
//  PIX_VALID        in   1           input pixel strobe
//  PIX_DATA         in   ADC_WIDHT   input pixel
//  OUT_VALID        out  1           output strobe, PIX_VALID delayed 1 cycle
//  OUT_DATA         out  ADC_WIDHT   corrected pixel
//  CAL_BUSY         out  1           high in ARM and CAL
//  CAL_DONE         out  1           one-cycle pulse when calibration completes
//  BAD_COUNT        out  7           valid table entries (0..MAX_BAD)
//  OVERFLOW         out  1           sticky: more than MAX_BAD bad pixels seen in the last calibration
// BEHAVIOUR
//  Reset: state IDLE; BAD_COUNT=0; OVERFLOW=0; OUT_VALID=0; OUT_DATA=0; CAL_DONE=0; CAL_BUSY=0.
//  Raster address
//  - Resets to 0 on FRAME_START&PIX_VALID; +1 per other valid pixel.
//  - Saturates at COLS*ROWS-1; never matches a table entry beyond that.
//  Latency: exactly 1 cycle, valid to valid; no backpressure; no bubbles inserted.
//  States
//  - IDLE: pass-through.
//      CAL_REQ -> ARM.
//  - ARM: correction continues with the old table.
//      FRAME_START&PIX_VALID -> CAL.
//      A FRAME_START in the same cycle as CAL_REQ is not consumed; calibration waits for the next frame.
//  - CAL: pass-through, no correction.
//      Entry clears BAD_COUNT and OVERFLOW.
//      Each valid pixel with PIX_DATA > level: if BAD_COUNT < MAX_BAD, write its address at index BAD_COUNT and increment; else set OVERFLOW.
//      Valid pixel at address COLS*ROWS-1 -> RUN, CAL_DONE=1 on the next cycle.
//      FRAME_START mid-CAL (short frame): restart CAL at that pixel; count cleared.
//      CAL_REQ in CAL is ignored.
//  - RUN: correction active.
//      rd_ptr=0 and last_good=0 at each FRAME_START pixel.
//      Valid pixel, rd_ptr < BAD_COUNT and addr == table[rd_ptr]: OUT_DATA = last_good; rd_ptr++.
//      Otherwise: OUT_DATA = PIX_DATA; last_good <= PIX_DATA.
//      Table entries are ascending (written in scan order), so one compare per pixel suffices.
//      CAL_REQ -> ARM.
//  - BAD_COUNT=0 in RUN is pure pass-through.
//  - The pixel that enters CAL is itself judged and recorded.
//  - RST mid-frame or mid-CAL: table invalidated (BAD_COUNT=0), IDLE, outputs as reset.
//  - OUT_DATA holds its last value while OUT_VALID=0.
// STRUCTURE
//  - ADC_WIDHT comes from define.v.
//  - New shared constants go into define.v: state encodings (IDLE=0, ARM=1, CAL=2, RUN=3) and BAD_CNT_W=7.
//  - Sub-module bad_pix_table: MAX_BAD x ADDR_W; synchronous write port; asynchronous read by rd_ptr.
//  - Top holds the FSM, the address counter, rd_ptr, last_good and the output register.
// TESTING (bench uses COLS=8, ROWS=4, MAX_BAD=4, level=1000)
//  1. No CAL_REQ, ramp frame 0..31 -> OUT_DATA equals input delayed 1 cycle; BAD_COUNT=0.
//  2. CAL_REQ, then calibration frame with 4095 at addr 5 and 17 -> BAD_COUNT=2, CAL_DONE one cycle after addr 31;
//     next frame of value 100+addr -> OUT_DATA at 5 = 104, at 17 = 116.
//  3. Calibration frame with bad pixels at 0,1,2,3,4,9 -> BAD_COUNT=4, OVERFLOW=1;
//     next frame: addrs 0..3 output 0, addr 4 passes through.
//  4. FRAME_START at addr 12 during CAL, bad pixel at old addr 3 -> table cleared, calibration restarts, CAL_DONE after 32 pixels.
//  5. RST asserted mid-RUN frame -> next cycle OUT_VALID=0, BAD_COUNT=0; later frames pass through unchanged.
//  6. CAL_REQ and FRAME_START in the same cycle -> state ARM, that frame still corrected with the old table, calibration on the following frame.

Source files
------------

// File: rtl/beaten_pix_sched_pkg.sv
// rtl/beaten_pix_sched_pkg.sv - shared constants for the beaten pixel scheduler
// Pixel width, FSM state encodings and the bad-count width used across the block.
package beaten_pix_sched_pkg;

    localparam int ADC_WIDHT = 12;
    localparam int BAD_CNT_W = 7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_CAL  = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    function automatic logic is_beaten(input logic [ADC_WIDHT-1:0] pix,
                                       input logic [ADC_WIDHT-1:0] level);
        return pix > level;
    endfunction

endpackage

// File: rtl/beaten_pix_sched_bad_pix_table.sv
// rtl/beaten_pix_sched_bad_pix_table.sv - bad pixel address table
// Synchronous write, asynchronous read; validity is tracked by the owner's count.
module bad_pix_table #(
    parameter int DEPTH = 64,
    parameter int AW    = 17,
    parameter int IW    = 6
) (
    input  logic          CLK,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [AW-1:0] i_wdata,
    input  logic [IW-1:0] i_ridx,
    output logic [AW-1:0] o_rdata
);

    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/beaten_pix_sched.sv
// rtl/beaten_pix_sched.sv - beaten pixel calibration and replacement scheduler
// One calibration frame fills the table; later frames replace listed pixels with the last good one.
module beaten_pix_sched
    import beaten_pix_sched_pkg::*;
#(
    parameter int COLS    = 384,
    parameter int ROWS    = 288,
    parameter int MAX_BAD = 64,
    parameter int ADDR_W  = 17
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CAL_REQ,
    input  logic [ADC_WIDHT-1:0] BEATEN_PIX_LEVEL,
    input  logic                 FRAME_START,
    input  logic                 PIX_VALID,
    input  logic [ADC_WIDHT-1:0] PIX_DATA,
    output logic                 OUT_VALID,
    output logic [ADC_WIDHT-1:0] OUT_DATA,
    output logic                 CAL_BUSY,
    output logic                 CAL_DONE,
    output logic [BAD_CNT_W-1:0] BAD_COUNT,
    output logic                 OVERFLOW
);

    localparam int                   IDX_W     = (MAX_BAD > 1) ? $clog2(MAX_BAD) : 1;
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [BAD_CNT_W-1:0] MAX_CNT   = BAD_CNT_W'(MAX_BAD);

    logic [1:0]           r_state;
    logic [ADDR_W-1:0]    r_next_addr;
    logic                 r_past_end;
    logic [BAD_CNT_W-1:0] r_bad_count;
    logic                 r_overflow;
    logic [BAD_CNT_W-1:0] r_rd_ptr;
    logic [ADC_WIDHT-1:0] r_last_good;
    logic                 r_out_valid;
    logic [ADC_WIDHT-1:0] r_out_data;
    logic                 r_cal_done;

    logic                 w_fs;
    logic [ADDR_W-1:0]    w_addr;
    logic                 w_addr_ok;
    logic                 w_at_last;
    logic                 w_cal_pix;
    logic                 w_corr;
    logic [BAD_CNT_W-1:0] w_rd;
    logic [ADC_WIDHT-1:0] w_last_good;
    logic [ADDR_W-1:0]    w_tab_rdata;
    logic                 w_hit;
    logic [BAD_CNT_W-1:0] w_cnt_base;
    logic                 w_ovf_base;
    logic                 w_bad;
    logic                 w_room;
    logic                 w_we;

    assign w_fs      = FRAME_START & PIX_VALID;
    assign w_addr    = w_fs ? '0 : r_next_addr;
    // Once the last raster address has gone by, nothing matches until the next frame start.
    assign w_addr_ok = w_fs | ~r_past_end;
    assign w_at_last = w_addr_ok & (w_addr == LAST_ADDR);

    // The frame start seen in ARM is the first calibration pixel.
    assign w_cal_pix = (r_state == ST_CAL) | ((r_state == ST_ARM) & w_fs);
    assign w_corr    = ~w_cal_pix & ((r_state == ST_RUN) | (r_state == ST_ARM));

    assign w_rd        = w_fs ? '0 : r_rd_ptr;
    assign w_last_good = w_fs ? '0 : r_last_good;
    assign w_hit       = PIX_VALID & w_corr & w_addr_ok & (w_rd < r_bad_count)
                         & (w_addr == w_tab_rdata);

    assign w_cnt_base = w_fs ? '0 : r_bad_count;
    assign w_ovf_base = w_fs ? 1'b0 : r_overflow;
    assign w_bad      = PIX_VALID & w_cal_pix & is_beaten(PIX_DATA, BEATEN_PIX_LEVEL);
    assign w_room     = w_cnt_base < MAX_CNT;
    assign w_we       = w_bad & w_room;

    bad_pix_table #(
        .DEPTH (MAX_BAD),
        .AW    (ADDR_W),
        .IW    (IDX_W)
    ) u_table (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_widx  (w_cnt_base[IDX_W-1:0]),
        .i_wdata (w_addr),
        .i_ridx  (w_rd[IDX_W-1:0]),
        .o_rdata (w_tab_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_next_addr <= '0;
            r_past_end  <= 1'b1;
            r_bad_count <= '0;
            r_overflow  <= 1'b0;
            r_rd_ptr    <= '0;
            r_last_good <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cal_done  <= 1'b0;
        end else begin
            r_cal_done  <= 1'b0;
            r_out_valid <= PIX_VALID;

            if (PIX_VALID) begin
                r_out_data  <= w_hit ? w_last_good : PIX_DATA;
                r_last_good <= w_hit ? w_last_good : PIX_DATA;
                r_rd_ptr    <= w_hit ? w_rd + 1'b1 : w_rd;
                r_next_addr <= (w_addr == LAST_ADDR) ? w_addr : w_addr + 1'b1;
                r_past_end  <= ~w_addr_ok | (w_addr == LAST_ADDR);
            end

            if (PIX_VALID & w_cal_pix) begin
                r_bad_count <= w_cnt_base + BAD_CNT_W'(w_we);
                r_overflow  <= w_ovf_base | (w_bad & ~w_room);
            end

            case (r_state)
                ST_IDLE: if (CAL_REQ) r_state <= ST_ARM;
                ST_ARM:  ;
                ST_CAL:  ;
                ST_RUN:  if (CAL_REQ) r_state <= ST_ARM;
                default: r_state <= ST_IDLE;
            endcase

            if (PIX_VALID & w_cal_pix) begin
                r_state    <= w_at_last ? ST_RUN : ST_CAL;
                r_cal_done <= w_at_last;
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_DATA  = r_out_data;
    assign CAL_BUSY  = (r_state == ST_ARM) | (r_state == ST_CAL);
    assign CAL_DONE  = r_cal_done;
    assign BAD_COUNT = r_bad_count;
    assign OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_beaten_pix_sched.sv
// tb/tb_beaten_pix_sched.sv - self-checking bench for beaten_pix_sched
// Vector table, directed frame sequences and randomized frames against a reference model.
module tb_beaten_pix_sched;
    import beaten_pix_sched_pkg::*;

    localparam int COLS    = 8;
    localparam int ROWS    = 4;
    localparam int MAX_BAD = 4;
    localparam int ADDR_W  = 5;
    localparam int NPIX    = COLS * ROWS;
    localparam int LEVEL   = 1000;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_CAL  = 2;
    localparam int M_RUN  = 3;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 CAL_REQ;
    logic [ADC_WIDHT-1:0] BEATEN_PIX_LEVEL;
    logic                 FRAME_START;
    logic                 PIX_VALID;
    logic [ADC_WIDHT-1:0] PIX_DATA;
    logic                 OUT_VALID;
    logic [ADC_WIDHT-1:0] OUT_DATA;
    logic                 CAL_BUSY;
    logic                 CAL_DONE;
    logic [BAD_CNT_W-1:0] BAD_COUNT;
    logic                 OVERFLOW;

    beaten_pix_sched #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .MAX_BAD (MAX_BAD),
        .ADDR_W  (ADDR_W)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .CAL_REQ          (CAL_REQ),
        .BEATEN_PIX_LEVEL (BEATEN_PIX_LEVEL),
        .FRAME_START      (FRAME_START),
        .PIX_VALID        (PIX_VALID),
        .PIX_DATA         (PIX_DATA),
        .OUT_VALID        (OUT_VALID),
        .OUT_DATA         (OUT_DATA),
        .CAL_BUSY         (CAL_BUSY),
        .CAL_DONE         (CAL_DONE),
        .BAD_COUNT        (BAD_COUNT),
        .OVERFLOW         (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: behaviour stated as frame-level rules over a list of bad addresses.
    int m_mode;
    int m_idx;
    int m_tab[$];
    bit m_ovf;
    int m_lg;
    int m_out;
    bit m_done;
    bit m_ovalid;

    int fr[64];
    int got[64];
    int done_at;

    typedef struct {
        bit pv;
        bit fs;
        int data;
        bit exp_valid;
        int exp_data;
        int exp_cnt;
    } vec_t;
    vec_t vt[33];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_idx    = -1;
        m_tab.delete();
        m_ovf    = 1'b0;
        m_lg     = 0;
        m_out    = 0;
        m_done   = 1'b0;
        m_ovalid = 1'b0;
    endtask

    function automatic bit in_tab(input int a);
        foreach (m_tab[k]) if (m_tab[k] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit pv, input bit fs, input int data, input bit req);
        int m0;
        bit fsq, aok, calp, corr, hit;
        m0       = m_mode;
        fsq      = fs && pv;
        m_done   = 1'b0;
        m_ovalid = pv;
        if (pv) begin
            if (fsq) m_idx = 0;
            else if (m_idx >= 0) m_idx++;
        end
        aok  = pv && (m_idx >= 0) && (m_idx < NPIX);
        calp = (m0 == M_CAL) || (m0 == M_ARM && fsq);
        corr = !calp && (m0 == M_RUN || m0 == M_ARM);
        if (pv) begin
            if (fsq) m_lg = 0;
            hit = corr && aok && in_tab(m_idx);
            if (hit) m_out = m_lg;
            else begin
                m_out = data;
                m_lg  = data;
            end
        end
        if (pv && calp) begin
            if (fsq) begin
                m_tab.delete();
                m_ovf = 1'b0;
            end
            if (data > LEVEL) begin
                if (m_tab.size() < MAX_BAD) m_tab.push_back(m_idx);
                else m_ovf = 1'b1;
            end
            m_mode = M_CAL;
            if (aok && m_idx == NPIX - 1) begin
                m_mode = M_RUN;
                m_done = 1'b1;
            end
        end
        if ((m0 == M_IDLE || m0 == M_RUN) && req) m_mode = M_ARM;
    endtask

    task automatic compare_model();
        int eb, ec;
        eb = (m_mode == M_ARM || m_mode == M_CAL) ? 1 : 0;
        ec = m_tab.size();
        checks++;
        if (OUT_VALID !== m_ovalid || int'(OUT_DATA) != m_out || int'(BAD_COUNT) != ec ||
            OVERFLOW !== m_ovf || int'(CAL_BUSY) != eb || CAL_DONE !== m_done) begin
            failures++;
            $display("FAIL model t=%0t valid=%0d/%0d data=%0d/%0d cnt=%0d/%0d ovf=%0d/%0d busy=%0d/%0d done=%0d/%0d (actual/expected)",
                     $time, OUT_VALID, m_ovalid, OUT_DATA, m_out, BAD_COUNT, ec,
                     OVERFLOW, m_ovf, CAL_BUSY, eb, CAL_DONE, m_done);
        end
    endtask

    task automatic cyc(input bit pv, input bit fs, input int data, input bit req);
        PIX_VALID   = pv;
        FRAME_START = fs;
        PIX_DATA    = ADC_WIDHT'(data);
        CAL_REQ     = req;
        model_step(pv, fs, data, req);
        @(posedge CLK);
        #1;
        compare_model();
    endtask

    task automatic do_reset(input bit pv);
        RST         = 1'b1;
        PIX_VALID   = pv;
        FRAME_START = 1'b0;
        CAL_REQ     = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        compare_model();
    endtask

    task automatic frame(input int req_at, input int len);
        done_at = -1;
        for (int i = 0; i < len; i++) begin
            cyc(1'b1, i == 0, fr[i], i == req_at);
            got[i] = int'(OUT_DATA);
            if (CAL_DONE) done_at = i;
        end
    endtask

    task automatic fill_ramp(input int base);
        for (int i = 0; i < NPIX; i++) fr[i] = base + i;
    endtask

    task automatic fill_flat(input int v);
        for (int i = 0; i < NPIX; i++) fr[i] = v;
    endtask

    initial begin
        int k;
        RST              = 1'b1;
        CAL_REQ          = 1'b0;
        BEATEN_PIX_LEVEL = ADC_WIDHT'(LEVEL);
        FRAME_START      = 1'b0;
        PIX_VALID        = 1'b0;
        PIX_DATA         = '0;

        k = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (i == 16) begin
                vt[k] = '{pv: 1'b0, fs: 1'b1, data: 999, exp_valid: 1'b0, exp_data: 15, exp_cnt: 0};
                k++;
            end
            vt[k] = '{pv: 1'b1, fs: (i == 0), data: i, exp_valid: 1'b1, exp_data: i, exp_cnt: 0};
            k++;
        end

        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_out_data",  int'(OUT_DATA), 0);
        check("rst_bad_count", int'(BAD_COUNT), 0);
        check("rst_overflow",  int'(OVERFLOW), 0);
        check("rst_cal_busy",  int'(CAL_BUSY), 0);
        check("rst_cal_done",  int'(CAL_DONE), 0);
        RST = 1'b0;
        model_reset();

        // Pass-through ramp with a gap cycle that carries a stray frame start.
        for (int i = 0; i < 33; i++) begin
            cyc(vt[i].pv, vt[i].fs, vt[i].data, 1'b0);
            check("t1_valid", int'(OUT_VALID), int'(vt[i].exp_valid));
            check("t1_data",  int'(OUT_DATA), vt[i].exp_data);
            check("t1_cnt",   int'(BAD_COUNT), vt[i].exp_cnt);
        end

        cyc(1'b0, 1'b0, 0, 1'b1);
        check("t2_busy_arm", int'(CAL_BUSY), 1);
        fill_flat(50);
        fr[5]  = 4095;
        fr[17] = 4095;
        frame(-1, NPIX);
        check("t2_cnt",     int'(BAD_COUNT), 2);
        check("t2_done_at", done_at, NPIX - 1);
        check("t2_ovf",     int'(OVERFLOW), 0);
        check("t2_busy",    int'(CAL_BUSY), 0);
        fill_ramp(100);
        frame(-1, NPIX);
        check("t2_px5",  got[5], 104);
        check("t2_px17", got[17], 116);
        check("t2_px6",  got[6], 106);

        cyc(1'b0, 1'b0, 0, 1'b1);
        fill_flat(50);
        fr[0] = 4095; fr[1] = 2000; fr[2] = 1001; fr[3] = 3000; fr[4] = 4095; fr[9] = 1500;
        frame(-1, NPIX);
        check("t3_cnt", int'(BAD_COUNT), 4);
        check("t3_ovf", int'(OVERFLOW), 1);
        fill_ramp(100);
        frame(-1, NPIX);
        for (int i = 0; i < 4; i++) check("t3_px_lo", got[i], 0);
        check("t3_px4", got[4], 104);
        check("t3_px9", got[9], 109);

        cyc(1'b0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 12; i++) cyc(1'b1, i == 0, (i == 3) ? 4095 : 50, 1'b0);
        check("t4_cnt_pre", int'(BAD_COUNT), 1);
        check("t4_busy",    int'(CAL_BUSY), 1);
        done_at = -1;
        for (int i = 0; i < NPIX; i++) begin
            cyc(1'b1, i == 0, (i == 7) ? 4095 : 60, (i == 4));
            if (i == 0) begin
                check("t4_cnt_restart", int'(BAD_COUNT), 0);
                check("t4_ovf_restart", int'(OVERFLOW), 0);
            end
            if (CAL_DONE) done_at = i;
        end
        check("t4_done_at", done_at, NPIX - 1);
        check("t4_cnt",     int'(BAD_COUNT), 1);

        fill_ramp(100);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, i == 0, fr[i], 1'b0);
            got[i] = int'(OUT_DATA);
        end
        check("t5_px7_corr", got[7], 106);
        do_reset(1'b1);
        check("t5_valid", int'(OUT_VALID), 0);
        check("t5_cnt",   int'(BAD_COUNT), 0);
        check("t5_data",  int'(OUT_DATA), 0);
        frame(-1, NPIX);
        check("t5_px7_pass", got[7], 107);

        cyc(1'b0, 1'b0, 0, 1'b1);
        fill_flat(50);
        fr[10] = 4095;
        frame(-1, NPIX);
        check("t6_cnt_a", int'(BAD_COUNT), 1);
        fill_ramp(100);
        frame(0, NPIX);
        check("t6_px10_old", got[10], 109);
        check("t6_busy",     int'(CAL_BUSY), 1);
        fill_flat(50);
        fr[20] = 4095;
        frame(-1, NPIX);
        check("t6_done_at", done_at, NPIX - 1);
        check("t6_cnt_b",   int'(BAD_COUNT), 1);
        fill_ramp(100);
        frame(-1, NPIX);
        check("t6_px20", got[20], 119);
        check("t6_px10", got[10], 110);

        // Random frames: short/long lengths, gaps, stray requests and occasional resets.
        for (int f = 0; f < 120; f++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 36)) : NPIX;
            if ($urandom_range(0, 5) == 0) cyc(1'b0, 1'b0, 0, 1'b1);
            for (int i = 0; i < len; i++) begin
                int d;
                while ($urandom_range(0, 7) == 0)
                    cyc(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                        ($urandom_range(0, 39) == 0));
                d = ($urandom_range(0, 11) == 0) ? int'($urandom_range(LEVEL, 4095))
                                                 : int'($urandom_range(0, LEVEL));
                cyc(1'b1, i == 0, d, ($urandom_range(0, 39) == 0));
                if ($urandom_range(0, 299) == 0) do_reset(1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
